// File: rtl/axis_dest_demux.sv
// AXI-Stream destination demultiplexer with per-port packet counters.
// Whole packets steer by head tdest; out-of-range packets are dropped.
module axis_dest_demux #(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int AXIS_DEST_WIDTH = 2,
   parameter int NUM_PORTS       = 4,
   parameter int COUNTER_WIDTH   = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic                                 s_axis_tlast,
   input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
   output logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [NUM_PORTS*AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [NUM_PORTS-1:0]                 m_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                 m_axis_tready,
   output logic [NUM_PORTS-1:0]                 m_axis_tlast,
   input  logic                                 rst_counters,
   output logic [NUM_PORTS*COUNTER_WIDTH-1:0]   pkt_counter,
   output logic [COUNTER_WIDTH-1:0]             drop_counter
);

   localparam int DW = AXIS_DATA_WIDTH;
   localparam int KW = AXIS_KEEP_WIDTH;
   localparam int SW = AXIS_DEST_WIDTH;
   localparam int NP = NUM_PORTS;
   localparam int CW = COUNTER_WIDTH;

   localparam logic [1:0] S_HEAD = 2'd0;
   localparam logic [1:0] S_FWD  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [SW-1:0]    sel_q, sel_d;
   logic [NP-1:0]    vld_q, lst_q;
   logic [NP*DW-1:0] dat_q;
   logic [NP*KW-1:0] kep_q;
   logic [NP*CW-1:0] pkt_q;
   logic [CW-1:0]    drp_q;

   logic [NP-1:0]    port_free;
   logic [NP-1:0]    load;
   logic [NP-1:0]    pkt_inc;
   logic             free_live;
   logic             free_sel;
   logic             live_in_range;
   logic             tready;
   logic             s_hs;
   logic             drop_inc;

   // A port can accept a beat when empty or draining this cycle
   always_comb begin
      port_free = ~vld_q | m_axis_tready;
   end

   // Look up readiness of the live head dest and the locked sel
   always_comb begin
      free_live = 1'b1;
      free_sel  = 1'b0;
      for (int i = 0; i < NP; i++) begin
         if (s_axis_tdest == SW'(i)) begin
            free_live = port_free[i];
         end
         if (sel_q == SW'(i)) begin
            free_sel = port_free[i];
         end
      end
   end

   assign live_in_range = int'(s_axis_tdest) < NP;

   // Input ready depends only on state and output occupancy
   always_comb begin
      tready = 1'b0;
      unique case (1'b1)
         (state_q == S_HEAD): tready = free_live;
         (state_q == S_FWD):  tready = free_sel;
         (state_q == S_DROP): tready = 1'b1;
         default:             tready = 1'b0;
      endcase
      if (!rst) begin
         tready = 1'b0;
      end
   end

   assign s_axis_tready = tready;
   assign s_hs          = s_axis_tvalid & tready;

   // Select which output register captures the accepted beat
   always_comb begin
      load = '0;
      for (int i = 0; i < NP; i++) begin
         if (s_hs && state_q == S_HEAD && s_axis_tdest == SW'(i)) begin
            load[i] = 1'b1;
         end
         if (s_hs && state_q == S_FWD && sel_q == SW'(i)) begin
            load[i] = 1'b1;
         end
      end
   end

   // Packet-level FSM: head sampling, forwarding and dropping
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      drop_inc = 1'b0;
      if (s_hs) begin
         unique case (1'b1)
            (state_q == S_HEAD): begin
               sel_d = s_axis_tdest;
               if (live_in_range) begin
                  state_d = s_axis_tlast ? S_HEAD : S_FWD;
               end else if (s_axis_tlast) begin
                  drop_inc = 1'b1;
               end else begin
                  state_d = S_DROP;
               end
            end
            (state_q == S_FWD): begin
               if (s_axis_tlast) begin
                  state_d = S_HEAD;
               end
            end
            (state_q == S_DROP): begin
               if (s_axis_tlast) begin
                  state_d  = S_HEAD;
                  drop_inc = 1'b1;
               end
            end
            default: state_d = S_HEAD;
         endcase
      end
   end

   // FSM and sel registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_HEAD;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   // Per-port output registers; refill and drain may coincide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         lst_q <= '0;
         dat_q <= '0;
         kep_q <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (load[i]) begin
               vld_q[i]            <= 1'b1;
               lst_q[i]            <= s_axis_tlast;
               dat_q[i*DW +: DW]   <= s_axis_tdata;
               kep_q[i*KW +: KW]   <= s_axis_tkeep;
            end else if (m_axis_tready[i]) begin
               vld_q[i] <= 1'b0;
            end
         end
      end
   end

   assign pkt_inc = vld_q & m_axis_tready & lst_q;

   // Saturating counters; synchronous clear overrides increments
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_q <= '0;
         drp_q <= '0;
      end else if (rst_counters) begin
         pkt_q <= '0;
         drp_q <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (pkt_inc[i] && pkt_q[i*CW +: CW] != CNT_MAX) begin
               pkt_q[i*CW +: CW] <= pkt_q[i*CW +: CW] + CW'(1);
            end
         end
         if (drop_inc && drp_q != CNT_MAX) begin
            drp_q <= drp_q + CW'(1);
         end
      end
   end

   assign m_axis_tdata  = dat_q;
   assign m_axis_tkeep  = kep_q;
   assign m_axis_tvalid = vld_q;
   assign m_axis_tlast  = lst_q & vld_q;
   assign pkt_counter   = pkt_q;
   assign drop_counter  = drp_q;

endmodule

// File: tb/tb_axis_dest_demux.sv
// Bench for axis_dest_demux: directed scenarios plus random traffic,
// checked by a packet-level queue model.
module tb_axis_dest_demux;

   localparam int NP = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [63:0]   s_tdata = '0;
   logic [7:0]    s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [1:0]    s_tdest = '0;
   logic [191:0]  m_tdata;
   logic [23:0]   m_tkeep;
   logic [2:0]    m_tvalid;
   logic [2:0]    m_tready = 3'b111;
   logic [2:0]    m_tlast;
   logic          rst_counters = 1'b0;
   logic [11:0]   pkt_counter;
   logic [3:0]    drop_counter;

   axis_dest_demux #(
      .AXIS_DATA_WIDTH(64),
      .AXIS_KEEP_WIDTH(8),
      .AXIS_DEST_WIDTH(2),
      .NUM_PORTS(NP),
      .COUNTER_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast),
      .s_axis_tdest(s_tdest),
      .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast),
      .rst_counters(rst_counters),
      .pkt_counter(pkt_counter),
      .drop_counter(drop_counter)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      int          cyc;
   } beat_t;

   beat_t      expq[NP][$];
   int         pc[NP];
   int         dc;
   bit         m_head = 1'b1;
   int         m_sel;
   int         cyc;
   bit         lat_chk = 1'b0;
   int         rdy_mode = 0;
   logic [2:0] man_rdy = 3'b111;
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v < 15) ? v + 1 : 15;
   endfunction

   // ready driver
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0) m_tready = 3'b111;
         else if (rdy_mode == 1) m_tready = 3'($urandom);
         else m_tready = man_rdy;
      end
   end

   // reference model and scoreboard
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            for (int p = 0; p < NP; p++) begin
               expq[p].delete();
               pc[p] = 0;
            end
            dc = 0;
            m_head = 1'b1;
         end else begin
            for (int p = 0; p < NP; p++)
               chk($sformatf("pkt_cnt%0d", p),
                   64'(pkt_counter[p*CW +: CW]), 64'(pc[p]));
            chk("drop_cnt", 64'(drop_counter), 64'(dc));
            for (int p = 0; p < NP; p++) begin
               if (m_tvalid[p] && m_tready[p]) begin
                  if (expq[p].size() == 0) begin
                     chk($sformatf("spurious%0d", p), 64'(m_tvalid[p]), 64'(0));
                  end else begin
                     beat_t b;
                     b = expq[p].pop_front();
                     chk($sformatf("data%0d", p), m_tdata[p*64 +: 64], b.d);
                     chk($sformatf("keep%0d", p), 64'(m_tkeep[p*8 +: 8]), 64'(b.k));
                     chk($sformatf("last%0d", p), 64'(m_tlast[p]), 64'(b.l));
                     if (lat_chk) chk("latency", 64'(cyc - b.cyc), 64'(1));
                     if (b.l) pc[p] = sat(pc[p]);
                  end
               end
            end
            if (s_tvalid && s_tready) begin
               if (m_head) m_sel = int'(s_tdest);
               if (m_sel < NP) begin
                  beat_t nb;
                  nb.d = s_tdata;
                  nb.k = s_tkeep;
                  nb.l = s_tlast;
                  nb.cyc = cyc;
                  expq[m_sel].push_back(nb);
               end else if (s_tlast) begin
                  dc = sat(dc);
               end
               m_head = s_tlast;
            end
            if (rst_counters) begin
               for (int p = 0; p < NP; p++) pc[p] = 0;
               dc = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0;
      rst_counters = 1'b0;
      rdy_mode = 0;
      rst = 1'b0;
      repeat (2) tick();
      chk("rst_tvalid", 64'(m_tvalid), 64'(0));
      chk("rst_tlast", 64'(m_tlast), 64'(0));
      chk("rst_tdata", m_tdata[63:0] | m_tdata[127:64] | m_tdata[191:128], 64'(0));
      chk("rst_tkeep", 64'(m_tkeep), 64'(0));
      chk("rst_tready", 64'(s_tready), 64'(0));
      chk("rst_pkt", 64'(pkt_counter), 64'(0));
      chk("rst_drop", 64'(drop_counter), 64'(0));
      rst = 1'b1;
      tick();
   endtask

   task automatic send(input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic [1:0] dst, output int w);
      bit acc;
      bit done;
      s_tdata = d;
      s_tkeep = k;
      s_tlast = l;
      s_tdest = dst;
      s_tvalid = 1'b1;
      w = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         acc = s_tready;
         tick();
         if (acc) begin
            done = 1'b1;
         end else begin
            w++;
            if (w > 500) begin
               chk("send_timeout", 64'(w), 64'(0));
               done = 1'b1;
            end
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int dst, input int len, input bit scramble,
                           input int gap_max);
      int w;
      logic [7:0] k;
      logic [1:0] dd;
      for (int b = 0; b < len; b++) begin
         k = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         dd = (b == 0 || !scramble) ? 2'(dst) : 2'($urandom_range(0, 3));
         send({$urandom, $urandom}, k, b == len - 1, dd, w);
         repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   task automatic drain();
      rdy_mode = 0;
      repeat (10) tick();
      for (int p = 0; p < NP; p++)
         chk($sformatf("drained%0d", p), 64'(expq[p].size()), 64'(0));
   endtask

   initial begin
      int w;
      int k;
      int c;
      bit acc;
      logic [3:0] pat;
      pat = 4'b1001;

      do_reset();

      // route three packets with full throughput
      lat_chk = 1'b1;
      send_pkt(0, 4, 1'b0, 0);
      send_pkt(2, 4, 1'b0, 0);
      send_pkt(1, 4, 1'b0, 0);
      drain();
      lat_chk = 1'b0;
      chk("route_pkt", 64'(pkt_counter), 64'h111);
      chk("route_drop", 64'(drop_counter), 64'(0));

      // out-of-range drop then normal packet
      do_reset();
      for (int b = 0; b < 5; b++) begin
         send({$urandom, $urandom}, 8'hff, b == 4, 2'd3, w);
         chk("drop_rdy", 64'(w), 64'(0));
         chk("drop_novalid", 64'(m_tvalid), 64'(0));
      end
      send_pkt(0, 3, 1'b0, 0);
      drain();
      chk("drop_cnt_end", 64'(drop_counter), 64'(1));
      chk("drop_pkt_end", 64'(pkt_counter), 64'h001);

      // backpressure on port 1 with ready pattern 1,0,0,1
      do_reset();
      rdy_mode = 2;
      man_rdy = 3'b111;
      k = 0;
      c = 0;
      s_tdata = {$urandom, $urandom};
      s_tkeep = 8'($urandom);
      s_tlast = 1'b0;
      s_tdest = 2'd1;
      s_tvalid = 1'b1;
      while (k < 8 && c < 200) begin
         man_rdy[1] = pat[c % 4];
         @(negedge clk);
         if (k > 0) chk("bp_tready", 64'(s_tready), 64'(pat[c % 4]));
         acc = s_tready;
         tick();
         if (acc) begin
            k++;
            s_tdata = {$urandom, $urandom};
            s_tkeep = 8'($urandom);
            s_tlast = (k == 7);
            s_tdest = 2'($urandom_range(0, 3));
         end
         c++;
      end
      s_tvalid = 1'b0;
      chk("bp_beats", 64'(k), 64'(8));
      drain();
      chk("bp_pkt1", 64'(pkt_counter[7:4]), 64'(1));

      // mid-packet tdest change is ignored
      do_reset();
      for (int b = 0; b < 4; b++)
         send({$urandom, $urandom}, 8'($urandom), b == 3,
              (b == 0) ? 2'd2 : 2'd0, w);
      drain();
      chk("midd_pkt", 64'(pkt_counter), 64'h100);

      // single-beat packets back to back
      do_reset();
      lat_chk = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send({$urandom, $urandom}, 8'($urandom), 1'b1, 2'(i % 2), w);
         chk("b2b_wait", 64'(w), 64'(0));
      end
      drain();
      lat_chk = 1'b0;
      chk("b2b_cnt0", 64'(pkt_counter[3:0]), 64'(4));
      chk("b2b_cnt1", 64'(pkt_counter[7:4]), 64'(4));

      // saturation and clear priority
      do_reset();
      for (int i = 0; i < 17; i++)
         send({$urandom, $urandom}, 8'($urandom), 1'b1, 2'd0, w);
      drain();
      chk("sat_cnt0", 64'(pkt_counter[3:0]), 64'(15));
      send({$urandom, $urandom}, 8'h0f, 1'b1, 2'd1, w);
      drain();
      chk("clr_pre1", 64'(pkt_counter[7:4]), 64'(1));
      send({$urandom, $urandom}, 8'h0f, 1'b1, 2'd3, w);
      chk("clr_predrop", 64'(drop_counter), 64'(1));
      rst_counters = 1'b1;
      send({$urandom, $urandom}, 8'h0f, 1'b1, 2'd3, w);
      rst_counters = 1'b0;
      chk("clr_drop", 64'(drop_counter), 64'(0));
      chk("clr_pkt", 64'(pkt_counter), 64'(0));
      send({$urandom, $urandom}, 8'h0f, 1'b1, 2'd1, w);
      rst_counters = 1'b1;
      tick();
      rst_counters = 1'b0;
      chk("clr_pkt1", 64'(pkt_counter[7:4]), 64'(0));
      drain();

      // asynchronous reset in the middle of a packet
      do_reset();
      send({$urandom, $urandom}, 8'hff, 1'b0, 2'd2, w);
      send({$urandom, $urandom}, 8'hff, 1'b0, 2'd2, w);
      #1;
      rst = 1'b0;
      #1;
      chk("arst_tvalid", 64'(m_tvalid), 64'(0));
      chk("arst_tdata", m_tdata[191:128], 64'(0));
      chk("arst_tready", 64'(s_tready), 64'(0));
      chk("arst_pkt", 64'(pkt_counter), 64'(0));
      tick();
      rst = 1'b1;
      tick();
      send_pkt(1, 2, 1'b0, 0);
      drain();
      chk("arst_after", 64'(pkt_counter), 64'h010);

      // randomized traffic with random backpressure
      do_reset();
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         rst_counters = ($urandom_range(0, 9) == 0);
         send_pkt($urandom_range(0, 3), $urandom_range(1, 6), 1'b1, 2);
         rst_counters = 1'b0;
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/axis_dest_demux.md
Name: axis_dest_demux

Overview:
- Sits directly downstream of the packet dispatcher.
- Consumes its AXI-Stream output: tdata, tkeep, tvalid, tlast and the tdest chosen by the TCAM lookup.
- Steers each whole packet to one of NUM_PORTS output streams (processing lanes / host queues).
- Drops packets whose tdest is out of range, and keeps per-port packet counters and a drop counter.

Parameters:
- AXIS_DATA_WIDTH, 64, stream data width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_DEST_WIDTH, 2, input tdest width.
- NUM_PORTS, 4, number of output streams; 1 to 2**AXIS_DEST_WIDTH.
- COUNTER_WIDTH, 32, width of each packet/drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tdest  in  AXIS_DEST_WIDTH  destination; sampled on the first beat only.
- m_axis_tdata  out  NUM_PORTS*AXIS_DATA_WIDTH  output data, port i at slice i.
- m_axis_tkeep  out  NUM_PORTS*AXIS_KEEP_WIDTH  output byte enables, flattened.
- m_axis_tvalid  out  NUM_PORTS  per-port valid.
- m_axis_tready  in  NUM_PORTS  per-port ready.
- m_axis_tlast  out  NUM_PORTS  per-port end of packet.
- rst_counters  in  1  synchronous clear of all counters.
- pkt_counter  out  NUM_PORTS*COUNTER_WIDTH  packets fully delivered per port.
- drop_counter  out  COUNTER_WIDTH  packets dropped for invalid dest.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to HEAD; all m_axis_tvalid=0, m_axis_tlast=0; tdata/tkeep registers=0.
  - All counters=0; s_axis_tready=0 while rst=0.
- FSM states: HEAD, FORWARD, DROP.
- HEAD: waiting for a first beat. On an s_axis handshake:
  - Latch sel=s_axis_tdest.
  - If sel<NUM_PORTS: the beat is loaded into output register sel. Go to FORWARD, or stay in HEAD if tlast=1.
  - Else: discard the beat. Go to DROP, or stay in HEAD with drop_counter incremented if tlast=1.
- FORWARD: every beat goes to port sel regardless of s_axis_tdest. A handshake with tlast=1 returns to HEAD.
- DROP: s_axis_tready=1 unconditionally and beats are discarded. A tlast handshake returns to HEAD and increments drop_counter by 1.
- Output stage: one register per port; latency is 1 cycle from input handshake to m_axis_tvalid.
- s_axis_tready rules:
  - HEAD: tready = !m_axis_tvalid[dest] | m_axis_tready[dest], using the live s_axis_tdest. If dest is out of range, tready=1.
  - FORWARD: tready = !m_axis_tvalid[sel] | m_axis_tready[sel].
  - tready must not depend on s_axis_tvalid.
- Output registers hold data and valid stable until m_axis_tready. Simultaneous drain and refill of the same port in one cycle is allowed, giving full throughput.
- Other ports drain independently while a packet is locked to sel. There is no interleaving on the input: a back-pressured sel stalls the input.
- pkt_counter[i] increments when port i completes an output handshake with m_axis_tlast=1.
- All counters saturate at 2**COUNTER_WIDTH-1 and never wrap.
- rst_counters=1 clears counters on the next clock edge. If it coincides with an increment, the clear wins (result is 0).
- A tdest change mid-packet is ignored; tdest is sampled only in HEAD.
- tkeep and tdata are passed through unmodified. A zero-tkeep beat is forwarded as-is.
- Asynchronous reset mid-packet: the partial packet is lost and no counter increments. After rst=1, the next beat is treated as a head.

Test Plan:
- Route: 3 packets of 4 beats, tdest=0,2,1, all m_axis_tready=1 → each packet appears only on its port with 1-cycle latency; pkt_counter = {0,1,1,1} for ports 3..0.
- Out-of-range drop: NUM_PORTS=3, packet tdest=3 of 5 beats → s_axis_tready=1 throughout, no m_axis_tvalid, drop_counter=1; next packet tdest=0 is delivered normally.
- Backpressure: port 1 m_axis_tready toggled 1,0,0,1 during an 8-beat packet → no beat lost or duplicated, s_axis_tready=0 during stall cycles, data order preserved, pkt_counter[1]=1.
- Mid-packet tdest change: tdest=2 on beat 0, tdest=0 on beats 1-3 → all 4 beats go to port 2.
- Single-beat packets back-to-back with tlast=1 and tdest alternating 0/1 → one beat per cycle sustained; counters 0 and 1 each equal N/2.
- Counters: force pkt_counter[0] near saturation (COUNTER_WIDTH=4, 16 packets) → holds at 15; rst_counters asserted in the same cycle as a tlast handshake → counter reads 0. Asynchronous reset mid-packet → outputs are 0 immediately, FSM is in HEAD.
